spi_transfer_sequencer: RTL and testbench

SPI_TRANSFER_SEQUENCER -- requirements
Module: spi_transfer_sequencer

---
 rtl/spi_transfer_sequencer.sv | 157 +++++++++++++++
 tb/tb_spi_transfer_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_transfer_sequencer.sv
// spi_transfer_sequencer: queues host SPI commands, runs one controller transfer at a time, returns read word.
// Optional macro SPI_SEQ_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES.
module spi_transfer_sequencer #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_data_i,
    input  logic [2:0]  cmd_bytes_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        ctrl_enable_o,
    output logic [31:0] ctrl_write_data_o,
    output logic [2:0]  ctrl_bytes_valid_o,
    input  logic [31:0] ctrl_read_data_i,
    input  logic [2:0]  ctrl_read_bytes_i
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [2:0]    state_q, state_d;
    logic [34:0]   fifo_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    cnt_q;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    bytes_q, bytes_d;
    logic [31:0]   rd_data_q;
    logic [2:0]    rd_cnt_q;
    logic          match_q;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          push, pop, hit, done;
    logic [34:0]   head;

    assign head        = fifo_q[rd_ptr_q];
    assign pop         = state_q == S_IDLE && cnt_q != 2'd0;
    assign cmd_ready_o = !rst_i && (cnt_q != 2'd2 || pop);
    assign push        = cmd_valid_i && cmd_ready_o;
    // Completion needs the matching count on two consecutive WAIT samples.
    assign hit         = state_q == S_WAIT && rd_cnt_q == bytes_q;
    assign done        = hit && match_q;

    assign ctrl_enable_o      = state_q == S_START || state_q == S_WAIT;
    assign ctrl_write_data_o  = wdata_q;
    assign ctrl_bytes_valid_o = bytes_q;
    assign rsp_valid_o        = state_q == S_RESP;
    assign rsp_data_o         = rsp_data_q;
    assign rsp_err_o          = rsp_err_q;

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_bytes_i, cmd_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop) rd_ptr_q <= !rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) to_q <= '0;
        else to_q <= to_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        bytes_d    = bytes_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        gap_d      = gap_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        to_d       = to_q;
`endif
        case (state_q)
            S_IDLE: if (pop) begin
                if (head[34:32] inside {[3'd1:3'd4]}) begin
                    wdata_d = head[31:0];
                    bytes_d = head[34:32];
                    state_d = S_START;
                end else begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            S_WAIT: if (done) begin
                rsp_data_d = rd_data_q;
                rsp_err_d  = 1'b0;
                gap_d      = '0;
                state_d    = S_GAP;
            end
`ifdef SPI_SEQ_TIMEOUT_EN
            else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                rsp_data_d = 32'd0;
                rsp_err_d  = 1'b1;
                gap_d      = '0;
                state_d    = S_GAP;
            end else to_d = to_q + 1'b1;
`endif
            S_GAP: if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_RESP;
                   else gap_d = gap_q + 1'b1;
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wdata_q    <= 32'd0;
            bytes_q    <= 3'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            gap_q      <= '0;
            rd_data_q  <= 32'd0;
            rd_cnt_q   <= 3'd0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            bytes_q    <= bytes_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            gap_q      <= gap_d;
            rd_data_q  <= ctrl_read_data_i;
            rd_cnt_q   <= ctrl_read_bytes_i;
            match_q    <= hit;
        end
    end
endmodule

// File: tb/tb_spi_transfer_sequencer.sv
// tb_spi_transfer_sequencer: directed checks of the SPI transfer sequencer with a simple controller model.
module tb_spi_transfer_sequencer;
    logic        clk_i = 0, rst_i = 1;
    logic        cmd_valid_i = 0, rsp_ready_i = 0;
    logic [31:0] cmd_data_i = 0;
    logic [2:0]  cmd_bytes_i = 0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, ctrl_enable_o;
    logic [31:0] rsp_data_o, ctrl_write_data_o, ctrl_read_data_i;
    logic [2:0]  ctrl_bytes_valid_o, ctrl_read_bytes_i;

    logic        manual = 0;
    logic [2:0]  man_bytes = 0, m_bytes = 0;
    logic [31:0] man_data = 0, m_data = 0, model_xor = 0;
    int          checks = 0, failures = 0, en_cycles = 0, rsp_cycles = 0;

    assign ctrl_read_bytes_i = manual ? man_bytes : m_bytes;
    assign ctrl_read_data_i  = manual ? man_data : m_data;

    spi_transfer_sequencer #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_data_i(cmd_data_i), .cmd_bytes_i(cmd_bytes_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .ctrl_enable_o(ctrl_enable_o), .ctrl_write_data_o(ctrl_write_data_o),
        .ctrl_bytes_valid_o(ctrl_bytes_valid_o),
        .ctrl_read_data_i(ctrl_read_data_i), .ctrl_read_bytes_i(ctrl_read_bytes_i)
    );

    always #5 clk_i = !clk_i;

    // Controller model: fill count climbs to the requested count while enabled.
    always @(posedge clk_i) begin
        if (ctrl_enable_o && m_bytes < ctrl_bytes_valid_o) m_bytes <= m_bytes + 3'd1;
        else if (!ctrl_enable_o) m_bytes <= 3'd0;
        m_data <= model_xor ^ ctrl_write_data_o;
    end

    always @(negedge clk_i) begin
        if (ctrl_enable_o) en_cycles <= en_cycles + 1;
        if (rsp_valid_o) rsp_cycles <= rsp_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] b);
        int n = 0;
        cmd_data_i = d;
        cmd_bytes_i = b;
        cmd_valid_i = 1;
        while (!cmd_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) chk("send_timeout", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clk_i);
        cmd_valid_i = 0;
    endtask

    task automatic wait_en(input logic v, input string tag);
        int n = 0;
        while (ctrl_enable_o !== v && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, {31'd0, ctrl_enable_o}, {31'd0, v});
    endtask

    task automatic recv(input logic [31:0] d, input logic e, input string tag);
        int n = 0;
        while (!rsp_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        repeat (3) @(negedge clk_i);
        chk({tag, "_data"}, rsp_data_o, d);
        chk({tag, "_err"}, {31'd0, rsp_err_o}, {31'd0, e});
        rsp_ready_i = 1;
        @(negedge clk_i);
        rsp_ready_i = 0;
        chk({tag, "_drop"}, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        int n, en0, rs0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_rvalid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rsp_data_o, 32'd0);
        chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_en", {31'd0, ctrl_enable_o}, 32'd0);
        chk("rst_wdata", ctrl_write_data_o, 32'd0);
        chk("rst_bytes", {29'd0, ctrl_bytes_valid_o}, 32'd0);
        rst_i = 0;
        @(negedge clk_i);
        chk("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);

        model_xor = 32'hA5A51234 ^ 32'hDEADBEEF;
        send(32'hA5A51234, 3'd4);
        wait_en(1, "t1_en_rise");
        chk("t1_wdata", ctrl_write_data_o, 32'hA5A51234);
        chk("t1_bytes", {29'd0, ctrl_bytes_valid_o}, 32'd4);
        wait_en(0, "t1_en_fall");
        n = 0;
        en0 = en_cycles;
        while (!rsp_valid_o && n < 100) begin
            n++;
            if (n == 8) chk("t1_gap_wdata", ctrl_write_data_o, 32'hA5A51234);
            @(negedge clk_i);
        end
        chk("t1_gap_len", n, 16);
        chk("t1_gap_en_low", en_cycles - en0, 0);
        recv(32'hDEADBEEF, 0, "t1");
        rs0 = rsp_cycles;
        repeat (20) @(negedge clk_i);
        chk("t1_single_rsp", rsp_cycles - rs0, 0);

        model_xor = 32'h0F0F0F0F;
        send(32'h11111111, 3'd1);
        send(32'h22222222, 3'd2);
        send(32'h33333333, 3'd3);
        chk("t2_full_ready", {31'd0, cmd_ready_o}, 32'd0);
        n = 0;
        while (!rsp_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        repeat (5) @(negedge clk_i);
        chk("t2_held_ready", {31'd0, cmd_ready_o}, 32'd0);
        recv(32'h1E1E1E1E, 0, "t2a");
        recv(32'h2D2D2D2D, 0, "t2b");
        recv(32'h3C3C3C3C, 0, "t2c");

        en0 = en_cycles;
        send(32'h12345678, 3'd0);
        recv(32'd0, 1, "t3_b0");
        send(32'h87654321, 3'd5);
        recv(32'd0, 1, "t3_b5");
        chk("t3_no_enable", en_cycles - en0, 0);

        manual = 1;
        send(32'hCAFE0002, 3'd2);
        wait_en(1, "t4_en_rise");
        repeat (2) @(negedge clk_i);
        man_data = 32'h0BADF00D;
        man_bytes = 3'd2;
        @(negedge clk_i);
        man_bytes = 3'd0;
        repeat (4) @(negedge clk_i);
        chk("t4_no_early", {31'd0, ctrl_enable_o}, 32'd1);
        man_bytes = 3'd1;
        repeat (2) @(negedge clk_i);
        man_bytes = 3'd2;
        wait_en(0, "t4_en_fall");
        recv(32'h0BADF00D, 0, "t4");
        man_bytes = 3'd0;

`ifdef SPI_SEQ_TIMEOUT_EN
        send(32'h55AA55AA, 3'd4);
        wait_en(1, "t5_en_rise");
        n = 0;
        while (ctrl_enable_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("t5_en_len", n, 65);
        recv(32'd0, 1, "t5");
`endif

        send(32'h44444444, 3'd4);
        wait_en(1, "t6_en_rise");
        send(32'h66666666, 3'd1);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        chk("t6_rst_en", {31'd0, ctrl_enable_o}, 32'd0);
        chk("t6_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 0;
        en0 = en_cycles;
        rs0 = rsp_cycles;
        repeat (40) @(negedge clk_i);
        chk("t6_no_en", en_cycles - en0, 0);
        chk("t6_no_rsp", rsp_cycles - rs0, 0);
        chk("t6_ready", {31'd0, cmd_ready_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
